// File: rtl/vector_ex_stage.sv
// Execute stage of the RSA vector CPU: lane-wise ALU plus sequential modular multiply.
// Ports:
//   clk, reset                   clock, async active-high reset
//   ALUControlE, VSIFlagE        op select, operand-B source
//   RD1E, RD2E, ImmE             lane operands, immediate / modulus
//   RegWriteE, MemWriteE         write requests (gated by StallE on output)
//   FlagsWriteE                  flag update enable
//   ALUResultE, WriteDataE       lane results, store data
//   RegWriteGatedE, MemWriteGatedE, StallE, FlagsE {Z,C}
module vector_ex_stage #(
    parameter int N = 8,
    parameter int R = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     ALUControlE,
    input  logic [1:0]     VSIFlagE,
    input  logic [R*N-1:0] RD1E,
    input  logic [R*N-1:0] RD2E,
    input  logic [N-1:0]   ImmE,
    input  logic           RegWriteE,
    input  logic           MemWriteE,
    input  logic           FlagsWriteE,
    output logic [R*N-1:0] ALUResultE,
    output logic [R*N-1:0] WriteDataE,
    output logic           RegWriteGatedE,
    output logic           MemWriteGatedE,
    output logic           StallE,
    output logic [1:0]     FlagsE
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_n;

    logic [N-1:0]  a_q [R];
    logic [N-1:0]  b_q [R];
    logic [N-1:0]  m_q [R];
    logic [N-1:0]  p_q [R];
    logic [CW-1:0] cnt;

    logic [N-1:0] op_a [R];
    logic [N-1:0] op_b [R];
    logic [N-1:0] alu  [R];
    logic [N:0]   sum  [R];
    logic [N:0]   dif  [R];
    logic [N:0]   t1   [R];
    logic [N:0]   t2   [R];
    logic [N-1:0] p_n  [R];
    logic [R-1:0] carry;
    logic         is_mm;
    logic         show_alu;
    logic         z_flag;
    logic         c_flag;

    assign is_mm    = (ALUControlE == 3'b110);
    assign show_alu = (state == IDLE) && !is_mm;

    // Operand selection; immediate mode on MODMUL means squaring.
    always_comb begin
        for (int i = 0; i < R; i++) begin
            op_a[i] = RD1E[i*N +: N];
            case (VSIFlagE)
                2'b01:   op_b[i] = RD2E[N-1:0];
                2'b10:   op_b[i] = is_mm ? op_a[i] : ImmE;
                default: op_b[i] = RD2E[i*N +: N];
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < R; i++) begin
            sum[i]   = {1'b0, op_a[i]} + {1'b0, op_b[i]};
            dif[i]   = {1'b0, op_a[i]} - {1'b0, op_b[i]};
            alu[i]   = '0;
            carry[i] = 1'b0;
            case (ALUControlE)
                3'b000: begin
                    alu[i]   = sum[i][N-1:0];
                    carry[i] = sum[i][N];
                end
                3'b001: begin
                    alu[i]   = dif[i][N-1:0];
                    carry[i] = dif[i][N];
                end
                3'b010:  alu[i] = op_a[i] & op_b[i];
                3'b011:  alu[i] = op_a[i] | op_b[i];
                3'b100:  alu[i] = op_a[i] ^ op_b[i];
                3'b101:  alu[i] = op_a[i] << op_b[i][2:0];
                3'b111:  alu[i] = op_b[i];
                default: alu[i] = '0;
            endcase
        end
    end

    // One MSB-first double-and-add step; P stays below M throughout.
    always_comb begin
        for (int i = 0; i < R; i++) begin
            t1[i] = {p_q[i], 1'b0};
            if (t1[i] >= {1'b0, m_q[i]})
                t1[i] = t1[i] - {1'b0, m_q[i]};
            t2[i] = b_q[i][cnt] ? t1[i] + {1'b0, a_q[i]} : t1[i];
            if (t2[i] >= {1'b0, m_q[i]})
                t2[i] = t2[i] - {1'b0, m_q[i]};
            p_n[i] = t2[i][N-1:0];
        end
    end

    always_comb begin
        ALUResultE = '0;
        for (int i = 0; i < R; i++)
            ALUResultE[i*N +: N] = show_alu ? alu[i] : p_q[i];
    end

    assign z_flag         = (ALUResultE == '0);
    assign c_flag         = show_alu && (|carry);
    assign WriteDataE     = RD2E;
    assign RegWriteGatedE = RegWriteE & ~StallE;
    assign MemWriteGatedE = MemWriteE & ~StallE;

    always_comb begin
        state_n = state;
        StallE  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mm) begin
                    StallE  = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                StallE = 1'b1;
                if (cnt == '0)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            FlagsE <= 2'b00;
            for (int i = 0; i < R; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                m_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (state == IDLE && is_mm) begin
                cnt <= CW'(N - 1);
                for (int i = 0; i < R; i++) begin
                    // A >= M (which covers M < 2) collapses to 0 so P never reaches M.
                    a_q[i] <= (op_a[i] < ImmE) ? op_a[i] : '0;
                    b_q[i] <= op_b[i];
                    m_q[i] <= ImmE;
                    p_q[i] <= '0;
                end
            end else if (state == MUL) begin
                cnt <= cnt - 1'b1;
                for (int i = 0; i < R; i++)
                    p_q[i] <= p_n[i];
            end
            if (FlagsWriteE && !StallE)
                FlagsE <= {z_flag, c_flag};
        end
    end
endmodule
